// File: rtl/modulo_tabuleiro_param_pkg.sv
// modulo_tabuleiro_param_pkg: shot result codes and FSM states shared by the board engine.
package modulo_tabuleiro_param_pkg;
    localparam logic [1:0] RES_MISS    = 2'b00;
    localparam logic [1:0] RES_HIT     = 2'b01;
    localparam logic [1:0] RES_REPEAT  = 2'b10;
    localparam logic [1:0] RES_INVALID = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_OVER = 2'b10
    } state_t;
endpackage

// File: rtl/modulo_tabuleiro_param_sincroniza_borda.sv
// modulo_sincroniza_borda: 2-FF synchroniser for an async input plus a one-cycle rising-edge pulse.
module modulo_sincroniza_borda (
    input  logic clk,
    input  logic clr,
    input  logic d_in,
    output logic pulse
);
    logic r_s1, r_s2, r_prev;
    always_ff @(posedge clk or negedge clr)
        if (!clr) {r_prev, r_s2, r_s1} <= 3'b000;
        else {r_prev, r_s2, r_s1} <= {r_s2, r_s1, d_in};
    assign pulse = r_s2 & ~r_prev;
endmodule

// File: rtl/modulo_tabuleiro_param.sv
// modulo_tabuleiro_param: naval-battle board engine with ship/attack maps, shot FSM,
// hit/shot counters, game-over detection and a column-scanned LED matrix driver.
module modulo_tabuleiro_param
    import modulo_tabuleiro_param_pkg::*;
#(
    parameter int ROWS     = 7,
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 20,
    localparam int N  = ROWS * COLS,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int NW = $clog2(N + 1),
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load_en,
    input  logic [N-1:0]  ship_map_in,
    input  logic [RW-1:0] atk_row,
    input  logic [CW-1:0] atk_col,
    input  logic          atk_btn,
    input  logic          mode,
    output logic [1:0]    result,
    output logic          result_valid,
    output logic [NW-1:0] hits,
    output logic [NW-1:0] shots,
    output logic          game_over,
    output logic [COLS-1:0] m_col,
    output logic [ROWS-1:0] m_line
);
    state_t r_state, w_state_nxt;
    logic [N-1:0]  r_ship, r_atk, w_atk_nxt, w_bit, w_map;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col, r_scan;
    logic [NW-1:0] r_hits, r_shots, w_hits_nxt, w_shots_nxt;
    logic [1:0]    r_result, w_res;
    logic          r_valid, w_edge, w_in_range, w_fresh, w_over_nxt;
    logic [IW-1:0] w_idx;
    logic [SCAN_DIV-1:0] r_pre;
    logic [ROWS-1:0] w_line;

    modulo_sincroniza_borda u_btn (
        .clk   (clk),
        .clr   (clr),
        .d_in  (atk_btn),
        .pulse (w_edge)
    );

    always_comb begin
        w_idx       = IW'(r_row) * IW'(COLS) + IW'(r_col);
        w_bit       = N'(1) << w_idx;
        w_in_range  = (int'(r_row) < ROWS) && (int'(r_col) < COLS);
        w_res       = !w_in_range ? RES_INVALID :
                      (r_atk & w_bit) != '0 ? RES_REPEAT :
                      (r_ship & w_bit) != '0 ? RES_HIT : RES_MISS;
        w_fresh     = (w_res == RES_HIT) || (w_res == RES_MISS);
        w_atk_nxt   = w_fresh ? (r_atk | w_bit) : r_atk;
        w_hits_nxt  = r_hits + NW'(w_res == RES_HIT);
        w_shots_nxt = r_shots + NW'(w_fresh);
        // Game over is judged on the map as it will be after this shot lands.
        w_over_nxt  = ((r_ship & ~w_atk_nxt) == '0) && (r_ship != '0);
        w_state_nxt = r_state == ST_IDLE ? (w_edge ? ST_EVAL : ST_IDLE) :
                      r_state == ST_EVAL ? (w_over_nxt ? ST_OVER : ST_IDLE) : r_state;
    end

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            r_state  <= ST_IDLE;
            r_ship   <= '0;
            r_atk    <= '0;
            r_hits   <= '0;
            r_shots  <= '0;
            r_result <= RES_MISS;
            r_valid  <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
        end else if (load_en) begin
            r_state  <= ST_IDLE;
            r_ship   <= ship_map_in;
            r_atk    <= '0;
            r_hits   <= '0;
            r_shots  <= '0;
            r_result <= RES_MISS;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (r_state == ST_EVAL);
            if (r_state == ST_IDLE && w_edge) begin
                r_row <= atk_row;
                r_col <= atk_col;
            end
            if (r_state == ST_EVAL) begin
                r_result <= w_res;
                r_atk    <= w_atk_nxt;
                r_hits   <= w_hits_nxt;
                r_shots  <= w_shots_nxt;
            end
        end

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            r_pre  <= '0;
            r_scan <= '0;
        end else begin
            r_pre <= r_pre + SCAN_DIV'(1);
            if (&r_pre) r_scan <= (int'(r_scan) == COLS - 1) ? '0 : r_scan + CW'(1);
        end

    always_comb begin
        w_map  = mode ? r_atk : r_ship;
        w_line = '1;
        for (int r = 0; r < ROWS; r++) w_line[r] = ~w_map[IW'(r * COLS) + IW'(r_scan)];
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign hits         = r_hits;
    assign shots        = r_shots;
    assign game_over    = ((r_ship & ~r_atk) == '0) && (r_ship != '0);
    assign m_col        = COLS'(1) << r_scan;
    assign m_line       = w_line;
endmodule

// File: tb/tb_modulo_tabuleiro_param.sv
// tb_modulo_tabuleiro_param: directed and randomized checks of the board engine against a cell-level model.
module tb_modulo_tabuleiro_param;
    localparam int ROWS = 7, COLS = 5, SCAN_DIV = 2, NC = ROWS * COLS;

    logic          clk = 0, clr = 0, load_en = 0, atk_btn = 0, mode = 0;
    logic [NC-1:0] ship_map_in = '0;
    logic [2:0]    atk_row = '0, atk_col = '0;
    logic [1:0]    result;
    logic          result_valid, game_over;
    logic [5:0]    hits, shots;
    logic [4:0]    m_col;
    logic [6:0]    m_line;

    int n_cmp = 0, n_err = 0, k;
    bit m_ship[NC];
    bit m_atk[NC];
    int m_hits, m_shots;
    bit m_over;

    modulo_tabuleiro_param #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .clr(clr), .load_en(load_en), .ship_map_in(ship_map_in),
        .atk_row(atk_row), .atk_col(atk_col), .atk_btn(atk_btn), .mode(mode),
        .result(result), .result_valid(result_valid), .hits(hits), .shots(shots),
        .game_over(game_over), .m_col(m_col), .m_line(m_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr)
        if (!clr) k <= 0;
        else k <= k + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_go();
        bit any = 0, left = 0;
        for (int i = 0; i < NC; i++) begin
            any  |= m_ship[i];
            left |= m_ship[i] & ~m_atk[i];
        end
        return any && !left;
    endfunction

    function automatic logic [1:0] model_shot(input int r, input int c);
        int i;
        if (r >= ROWS || c >= COLS) return 2'b11;
        i = r * COLS + c;
        if (m_atk[i]) return 2'b10;
        m_atk[i] = 1;
        m_shots++;
        if (m_ship[i]) begin
            m_hits++;
            return 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic model_clear(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) begin
            m_ship[i] = v[i];
            m_atk[i]  = 0;
        end
        m_hits = 0; m_shots = 0; m_over = 0;
    endtask

    task automatic check_state();
        check("hits", 64'(hits), 64'(m_hits));
        check("shots", 64'(shots), 64'(m_shots));
        check("game_over", 64'(game_over), 64'(model_go()));
    endtask

    task automatic check_scan();
        int col;
        logic [6:0] el;
        col = (k / 4) % COLS;
        for (int r = 0; r < ROWS; r++) el[r] = ~(mode ? m_atk[r * COLS + col] : m_ship[r * COLS + col]);
        check("m_col", 64'(m_col), 64'(1 << col));
        check("m_line", 64'(m_line), 64'(el));
    endtask

    task automatic load(input logic [NC-1:0] v);
        ship_map_in = v;
        load_en = 1;
        tick();
        load_en = 0;
        model_clear(v);
        check("load_valid", 64'(result_valid), 0);
        check("load_result", 64'(result), 0);
        check_state();
    endtask

    task automatic fire(input int r, input int c, input int hold);
        logic [1:0] er = 2'b00;
        bit ev;
        int nv = 0;
        ev = !m_over;
        if (ev) begin
            er = model_shot(r, c);
            m_over = model_go();
        end
        atk_row = 3'(r); atk_col = 3'(c); atk_btn = 1;
        for (int i = 1; i <= hold + 4; i++) begin
            if (i == hold + 1) atk_btn = 0;
            tick();
            if (result_valid) nv++;
            if (i == 3) check("valid_early", 64'(result_valid), 0);
            if (i == 4) begin
                check("valid_lat", 64'(result_valid), 64'(ev));
                if (ev) check("result", 64'(result), 64'(er));
            end
        end
        check("valid_cnt", 64'(nv), 64'(ev));
        check_state();
    endtask

    initial begin
        logic [NC-1:0] v;
        #1;
        model_clear('0);
        check("rst_m_col", 64'(m_col), 64'h01);
        check("rst_m_line", 64'(m_line), 64'h7F);
        check("rst_valid", 64'(result_valid), 0);
        check("rst_result", 64'(result), 0);
        check_state();
        tick(); tick();
        clr = 1;

        load(NC'(3));
        fire(0, 0, 6);
        fire(3, 2, 6);
        fire(0, 0, 6);

        mode = 1;
        #1 check_scan();
        repeat (24) begin
            tick();
            check_scan();
        end
        mode = 0;
        #1 check_scan();

        fire(7, 0, 6);
        fire(0, 5, 6);
        fire(4, 4, 100);
        fire(0, 1, 6);
        check("over_flag", 64'(game_over), 1);
        fire(1, 1, 6);
        load('0);

        load(NC'(1));
        atk_row = 0; atk_col = 0; atk_btn = 1;
        tick(); tick();
        ship_map_in = NC'(4);
        load_en = 1;
        tick();
        load_en = 0;
        model_clear(NC'(4));
        repeat (4) begin
            check("prio_valid", 64'(result_valid), 0);
            tick();
        end
        atk_btn = 0;
        repeat (3) tick();
        check_state();
        fire(0, 2, 6);

        load(NC'(3));
        atk_row = 0; atk_col = 1; atk_btn = 1;
        repeat (3) tick();
        clr = 0;
        #1;
        model_clear('0);
        check("abort_m_col", 64'(m_col), 64'h01);
        check("abort_m_line", 64'(m_line), 64'h7F);
        check("abort_valid", 64'(result_valid), 0);
        check("abort_result", 64'(result), 0);
        check_state();
        atk_btn = 0;
        tick();
        clr = 1;
        repeat (4) begin
            tick();
            check("abort_post_valid", 64'(result_valid), 0);
        end

        for (int g = 0; g < 6; g++) begin
            v = '0;
            repeat ($urandom_range(1, 4)) v[$urandom_range(0, 1) * COLS + $urandom_range(0, COLS - 1)] = 1'b1;
            load(v);
            for (int s = 0; s < 25; s++) begin
                mode = 1'($urandom_range(0, 1));
                fire($urandom_range(0, 2) == 0 ? $urandom_range(0, 7) : $urandom_range(0, 1),
                     $urandom_range(0, 5), $urandom_range(2, 8));
                check_scan();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
